// File: rtl/uart_rx_fifo_if.sv
// CPU-side view of the UART receive FIFO.
// master = bus/load path, slave = receiver.
interface uart_rx_fifo_if;
  logic       rd;
  logic       err_clr;
  logic [7:0] data;
  logic       empty;
  logic       full;
  logic       overrun;
  logic       frame_err;

  modport master (
    output rd, err_clr,
    input  data, empty, full, overrun, frame_err
  );

  modport slave (
    input  rd, err_clr,
    output data, empty, full, overrun, frame_err
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with oversampling deframer
// and a small circular FIFO for the CPU data register.
module uart_rx_fifo #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rx,
  uart_rx_fifo_if.slave  bus
);

  localparam int T  = CLK_FREQ / BAUD_RATE;
  localparam int H  = (T / 2 > 1) ? T / 2 : 1;
  localparam int CW = (T > 1) ? $clog2(T) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] C_HALF = CW'(H - 1);
  localparam logic [CW-1:0] C_BIT  = CW'(T - 1);
  localparam logic [CW-1:0] C_ONE  = CW'(1);
  localparam logic [AW-1:0] P_ONE  = AW'(1);
  localparam logic [AW:0]   N_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   N_FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  logic [1:0]    r_sync;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [7:0]    r_shift;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          r_overrun;
  logic          r_frame_err;

  state_t        w_state_nx;
  logic [CW-1:0] w_cnt_nx;
  logic [2:0]    w_idx_nx;
  logic [7:0]    w_shift_nx;
  logic          w_rx_s;
  logic          w_push;
  logic          w_ferr_set;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_wr;
  logic          w_ovr_set;

  // Line idles high, so the synchronizer resets to 1.
  always_ff @(posedge clk) begin
    if (rst) r_sync <= 2'b11;
    else     r_sync <= {r_sync[0], rx};
  end

  assign w_rx_s = r_sync[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_idx   <= w_idx_nx;
      r_shift <= w_shift_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_idx_nx   = r_idx;
    w_shift_nx = r_shift;
    w_push     = 1'b0;
    w_ferr_set = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!w_rx_s) begin
          w_cnt_nx   = C_HALF;
          w_state_nx = S_START;
        end
      end
      S_START: begin
        if (r_cnt != '0) begin
          w_cnt_nx = r_cnt - C_ONE;
        end else if (w_rx_s) begin
          w_state_nx = S_IDLE;
        end else begin
          w_state_nx = S_DATA;
          w_idx_nx   = '0;
          w_cnt_nx   = C_BIT;
        end
      end
      S_DATA: begin
        if (r_cnt != '0) begin
          w_cnt_nx = r_cnt - C_ONE;
        end else begin
          w_shift_nx[r_idx] = w_rx_s;
          w_cnt_nx          = C_BIT;
          w_idx_nx          = r_idx + 3'd1;
          if (r_idx == 3'd7) w_state_nx = S_STOP;
        end
      end
      S_STOP: begin
        if (r_cnt != '0) begin
          w_cnt_nx = r_cnt - C_ONE;
        end else if (w_rx_s) begin
          w_push     = 1'b1;
          w_state_nx = S_IDLE;
        end else begin
          w_ferr_set = 1'b1;
          w_state_nx = S_BREAK;
        end
      end
      S_BREAK: begin
        if (w_rx_s) w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == N_FULL);
  assign w_pop     = bus.rd && !w_empty;
  // A pop in the same cycle frees the slot for a push into a full FIFO.
  assign w_wr      = w_push && (!w_full || w_pop);
  assign w_ovr_set = w_push && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= r_shift;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + P_ONE;
      if (w_pop) r_rptr <= r_rptr + P_ONE;
      if (w_wr && !w_pop)      r_count <= r_count + N_ONE;
      else if (!w_wr && w_pop) r_count <= r_count - N_ONE;
      r_overrun   <= w_ovr_set  | (r_overrun   & ~bus.err_clr);
      r_frame_err <= w_ferr_set | (r_frame_err & ~bus.err_clr);
    end
  end

  assign bus.data      = w_empty ? 8'h00 : r_mem[r_rptr];
  assign bus.empty     = w_empty;
  assign bus.full      = w_full;
  assign bus.overrun   = r_overrun;
  assign bus.frame_err = r_frame_err;

endmodule
